// File: rtl/mem_port.sv
// mem_port: handshaked MAR/MDR memory port; define MEM_PORT_TIMEOUT_EN to abort requests unacknowledged after TIMEOUT cycles.
module mem_port #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_rd,
  input  logic                  start_wr,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] wdata_in,
  input  logic                  oe_a,
  output tri   [DATA_WIDTH-1:0] a,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] mdr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, FINISH} state_t;
  state_t state, state_n;
  logic   timeout;
  logic   req;
  assign req = state == READ || state == WRITE;
`ifdef MEM_PORT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign timeout = cnt == CW'(TIMEOUT);
  always_ff @(posedge clk) begin
    if (rst || state_n != state) cnt <= '0;
    else if (req) cnt <= cnt + 1'b1;
  end
`else
  assign timeout = TIMEOUT < 1;
`endif
  // an ack always takes precedence over a timeout reached in the same cycle
  always_comb begin
    state_n = state;
    case (state)
      IDLE:        state_n = start_rd ? READ : start_wr ? WRITE : IDLE;
      READ, WRITE: state_n = mem_ack ? FINISH : timeout ? IDLE : state;
      default:     state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mdr       <= '0;
    end else begin
      state  <= state_n;
      busy   <= state_n != IDLE;
      done   <= state_n == FINISH;
      err    <= req && state_n == IDLE;
      mem_rd <= state_n == READ;
      mem_wr <= state_n == WRITE;
      if (state == IDLE && (start_rd || start_wr)) mem_addr <= addr_in;
      if (state == IDLE && start_wr && !start_rd) mem_wdata <= wdata_in;
      if (req && mem_ack) mdr <= state == READ ? mem_rdata : mem_wdata;
    end
  end
  assign a = oe_a ? mdr : {DATA_WIDTH{1'bz}};
endmodule
